// File: rtl/pulse_period_meter.sv
// Pulse period meter: counts clock cycles between rising edges of pulse and hands each
// period to a consumer over valid/ack. Optional input synchronizer: define PULSE_SYNC_EN.
module pulse_period_meter #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse,
    input  logic             ack,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             busy,
    output logic             overflow,
    output logic             lost
);

    localparam logic [WIDTH-1:0] MaxCount = '1;
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);

    typedef enum logic {StIdle, StMeasure} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             lost_q, lost_d;
    logic             pulse_dly_q;
    logic             pulse_s;
    logic             rise;
    logic             result;

`ifdef PULSE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pulse};
        end
    end

    assign pulse_s = sync_q[1];
`else
    assign pulse_s = pulse;
`endif

    assign rise = pulse_s & ~pulse_dly_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        lost_d     = lost_q;
        result     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rise) begin
                    cnt_d      = One;
                    overflow_d = 1'b0;
                    state_d    = StMeasure;
                end
            end
            StMeasure: begin
                // A rise on the terminal count still reports MaxCount rather than overflowing.
                if (rise) begin
                    result = 1'b1;
                    cnt_d  = One;
                end else if (cnt_q == MaxCount) begin
                    overflow_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            default: state_d = StIdle;
        endcase

        if (valid_q && ack) begin
            valid_d = 1'b0;
            lost_d  = 1'b0;
        end
        // A new result beats a same-edge ack; it only counts as lost if nobody took the old one.
        if (result) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            if (valid_q && !ack) begin
                lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            lost_q      <= 1'b0;
            pulse_dly_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            lost_q      <= lost_d;
            pulse_dly_q <= pulse_s;
        end
    end

    assign period   = period_q;
    assign valid    = valid_q;
    assign busy     = (state_q == StMeasure);
    assign overflow = overflow_q;
    assign lost     = lost_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: a WIDTH=20 instance for the general cases and a
// WIDTH=4 instance for overflow boundaries, both sharing the same stimulus.
module tb_pulse_period_meter;

`ifdef PULSE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pulse;
    logic        ack;
    logic [19:0] period0;
    logic        valid0, busy0, overflow0, lost0;
    logic [3:0]  period1;
    logic        valid1, busy1, overflow1, lost1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_period_meter #(.WIDTH(20)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .pulse    (pulse),
        .ack      (ack),
        .period   (period0),
        .valid    (valid0),
        .busy     (busy0),
        .overflow (overflow0),
        .lost     (lost0)
    );

    pulse_period_meter #(.WIDTH(4)) u_dut4 (
        .clk      (clk),
        .reset    (reset),
        .pulse    (pulse),
        .ack      (ack),
        .period   (period1),
        .valid    (valid1),
        .busy     (busy1),
        .overflow (overflow1),
        .lost     (lost1)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise pulse for h cycles; returns just after the h-th edge.
    task automatic rise(input int h);
        pulse = 1'b1;
        step(h);
        pulse = 1'b0;
    endtask

    task automatic ack_once();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        pulse = 1'b0;
        ack   = 1'b0;
        reset = 1'b1;
        step(3);
        chk("rst_period", 32'(period0), 0);
        chk("rst_valid", 32'(valid0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_overflow", 32'(overflow0), 0);
        chk("rst_lost", 32'(lost0), 0);
        reset = 1'b0;

        // Period 10, one-cycle high pulses
        rise(1);
        step(LAT);
        chk("first_busy", 32'(busy0), 1);
        chk("first_valid", 32'(valid0), 0);
        step(9 - LAT);
        rise(1);
        step(LAT);
        chk("p10_valid", 32'(valid0), 1);
        chk("p10_period", 32'(period0), 10);
        ack_once();
        chk("p10_ack_valid", 32'(valid0), 0);
        chk("p10_ack_period", 32'(period0), 10);
        step(8 - LAT);

        // Period 10, four-cycle high pulses
        rise(4);
        ack_once();
        step(5);
        rise(4);
        chk("p10w_valid", 32'(valid0), 1);
        chk("p10w_period", 32'(period0), 10);
        chk("p10w_lost", 32'(lost0), 0);
        ack_once();
        chk("p10w_ack_valid", 32'(valid0), 0);

        // Periods 8 then 12 without ack
        step(3);
        rise(1);
        step(LAT);
        chk("p8_period", 32'(period0), 8);
        chk("p8_lost", 32'(lost0), 0);
        step(11 - LAT);
        rise(1);
        step(LAT);
        chk("p12_period", 32'(period0), 12);
        chk("p12_valid", 32'(valid0), 1);
        chk("p12_lost", 32'(lost0), 1);
        ack_once();
        chk("p12_ack_valid", 32'(valid0), 0);
        chk("p12_ack_lost", 32'(lost0), 0);

        // Pending period 6, then period 7 completes on the same edge as ack
        step(4 - LAT);
        rise(1);
        step(6);
        pulse = 1'b1;
        ack   = (LAT == 0);
        step(1);
        pulse = 1'b0;
        if (LAT > 0) begin
            step(LAT - 1);
            ack = 1'b1;
            step(1);
        end
        ack = 1'b0;
        chk("p7_ack_valid", 32'(valid0), 1);
        chk("p7_ack_period", 32'(period0), 7);
        chk("p7_ack_lost", 32'(lost0), 0);
        ack_once();

        // Reset in the middle of a measurement (cnt=6)
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_rst_period", 32'(period0), 0);
        chk("mid_rst_valid", 32'(valid0), 0);
        chk("mid_rst_busy", 32'(busy0), 0);
        rise(1);
        step(LAT);
        chk("post_rst_first_valid", 32'(valid0), 0);
        chk("post_rst_first_busy", 32'(busy0), 1);
        step(8 - LAT);
        rise(1);
        step(LAT);
        chk("post_rst_period", 32'(period0), 9);
        chk("post_rst_valid", 32'(valid0), 1);

        // Single edge then a long quiet stretch on the wide instance
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        rise(1);
        step(50);
        chk("quiet_busy", 32'(busy0), 1);
        chk("quiet_valid", 32'(valid0), 0);
        chk("quiet_overflow", 32'(overflow0), 0);

        // WIDTH=4 boundaries: MAXC=15
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        rise(1);
        step(15 + LAT);
        chk("w4_ovf", 32'(overflow1), 1);
        chk("w4_ovf_busy", 32'(busy1), 0);
        chk("w4_ovf_valid", 32'(valid1), 0);
        rise(1);
        step(LAT);
        chk("w4_clear_ovf", 32'(overflow1), 0);
        chk("w4_rearm_busy", 32'(busy1), 1);
        chk("w4_rearm_valid", 32'(valid1), 0);
        step(4 - LAT);
        rise(1);
        step(LAT);
        chk("w4_p5_period", 32'(period1), 5);
        chk("w4_p5_valid", 32'(valid1), 1);
        ack_once();
        step(13 - LAT);
        rise(1);
        step(LAT);
        chk("w4_p15_period", 32'(period1), 15);
        chk("w4_p15_valid", 32'(valid1), 1);
        chk("w4_p15_ovf", 32'(overflow1), 0);
        chk("w4_p15_busy", 32'(busy1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
